tone_sequencer: RTL and testbench
=================================

TONE_SEQUENCER -- requirements
Module: tone_sequencer

Interface
REQ-001 SHALL have parameter STEPS, default 8, pattern table depth (power of two).
REQ-002 SHALL have parameter PW, default 19, note period width in clocks.
REQ-003 SHALL have parameter DW, default 26, step duration width in clocks.
REQ-004 SHALL have parameter GAP_CYCLES, default 500000, silent gap length (used only under REQ-032).
REQ-005 SHALL have port CLK  input  1  50 MHz clock; single clock domain.
REQ-006 SHALL have port RST_N  input  1  reset; asynchronous, active-low.
REQ-007 SHALL have port WR_EN  input  1  pattern write strobe.
REQ-008 SHALL have port WR_ADDR  input  log2(STEPS)  pattern entry index.
REQ-009 SHALL have port WR_PERIOD  input  PW  tone period in clocks; 0 or 1 = rest.
REQ-010 SHALL have port WR_DUR  input  DW  step duration in clocks; 0 treated as 1.
REQ-011 SHALL have port START  input  1  single-cycle start pulse.
REQ-012 SHALL have port STOP  input  1  single-cycle abort pulse.
REQ-013 SHALL have port LOOP  input  1  level; replay from step 0 after the last step.
REQ-014 SHALL have port BUSY  output  1  high outside IDLE.
REQ-015 SHALL have port STEP  output  log2(STEPS)  index of the entry being played.
REQ-016 SHALL have port PERIOD  output  PW  period currently driven to the divider.
REQ-017 SHALL have port SPEAKER  output  1  registered square-wave audio output.
REQ-018 SHALL have port DONE  output  1  one-cycle pulse at normal end of sequence.

Function
REQ-019 SHALL implement FSM states IDLE, LOAD, PLAY (plus GAP per REQ-032).
REQ-020 SHALL store WR_PERIOD/WR_DUR into entry WR_ADDR on any cycle with WR_EN=1, in any state.
REQ-021 SHALL move IDLE->LOAD on the edge sampling START=1; BUSY=1 and STEP=0 from the next cycle.
REQ-022 SHALL in LOAD (exactly 1 cycle) latch entry STEP into PERIOD and the duration counter, then enter PLAY.
REQ-023 SHALL remain in PLAY exactly max(DUR,1) cycles, then advance.
REQ-024 SHALL on leaving PLAY with STEP<STEPS-1 increment STEP and enter LOAD.
REQ-025 SHALL on leaving PLAY with STEP=STEPS-1: if LOOP=1, set STEP=0 and enter LOAD; else pulse DONE for 1 cycle, enter IDLE, drive PERIOD=0.
REQ-026 SHALL make a write to the entry being played take effect only at its next LOAD.
REQ-027 SHALL ignore START while BUSY=1.
REQ-028 SHALL on STOP=1 in any non-IDLE state enter IDLE next cycle with SPEAKER=0, PERIOD=0, STEP=0, and no DONE; STOP wins over simultaneous START.
REQ-029 SHALL restart the tone counter at 0 on every LOAD; in PLAY it counts 0..PERIOD-1 and wraps.
REQ-030 SHALL drive SPEAKER=1 iff state=PLAY, PERIOD>=2 and counter >= PERIOD>>1 (registered, 1 cycle behind counter); otherwise 0.

Reset
REQ-031 SHALL on RST_N=0, asynchronously and at any point mid-sequence: state=IDLE, BUSY=0, STEP=0, PERIOD=0, SPEAKER=0, DONE=0, all counters 0, all table entries 0.

Configuration
REQ-032 SHALL, when TONE_SEQ_GAP_EN is defined, insert state GAP of GAP_CYCLES cycles (SPEAKER=0, PERIOD=0) between every PLAY and the following LOAD, including the loop wrap but not before IDLE; without the macro PLAY goes directly to LOAD/IDLE and no GAP logic exists.

Structure
REQ-033 SHALL take the FSM state enum and note-period constants (C3=382233, D3=340529, F3=286352, A3=227272) from shared package tone_pkg.
REQ-034 SHALL instantiate one sub-module tone_divider (tone counter + SPEAKER register, inputs enable/restart/period).

Verification
REQ-035 SHALL cover: entries {8,16},{4,8},{0,4},{10,12}... (8 entries), START, LOOP=0 -> BUSY at +1, PLAY at +2, STEP 0..7, SPEAKER period 8 duty 4/8 in step 0, silent in step 2, DONE one pulse, BUSY=0.
REQ-036 SHALL cover: LOOP=1, all DUR=5 -> STEP wraps 7->0 via LOAD, no DONE, each PLAY exactly 5 cycles.
REQ-037 SHALL cover: STOP at step 3 mid-PLAY with START same cycle -> IDLE next cycle, SPEAKER=0, no DONE, no restart.
REQ-038 SHALL cover: rewrite entry 2 period 8->6 while step 2 plays -> step 2 keeps 8; next loop pass uses 6.
REQ-039 SHALL cover: RST_N low mid-PLAY -> outputs zero immediately (asynchronously); table reads back 0 on replay.
REQ-040 SHALL cover: TONE_SEQ_GAP_EN with GAP_CYCLES=3 -> 3 silent cycles between steps, none before DONE.

Source files
------------

// File: rtl/tone_pkg.sv
// tone_pkg: shared FSM state encoding and note-period constants for the tone sequencer.
// The GAP state exists only when TONE_SEQ_GAP_EN is defined.
package tone_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_PLAY = 2'd2
`ifdef TONE_SEQ_GAP_EN
        , ST_GAP = 2'd3
`endif
    } state_e;

    // Note periods in 50 MHz clocks (one full square-wave cycle)
    localparam int unsigned NOTE_C3 = 382233;
    localparam int unsigned NOTE_D3 = 340529;
    localparam int unsigned NOTE_F3 = 286352;
    localparam int unsigned NOTE_A3 = 227272;

endpackage

// File: rtl/tone_divider.sv
// tone_divider: free-running tone counter plus registered square-wave output.
// The counter is held at 0 unless enabled; the speaker bit lags the counter by one clock.
module tone_divider
    import tone_pkg::*;
#(
    parameter int PW = 19
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          enable_i,
    input  logic          restart_i,
    input  logic [PW-1:0] period_i,
    output logic          speaker_o
);

    logic [PW-1:0] cnt_q;
    logic          audible;

    // Periods 0 and 1 are rests: no counting, no output
    assign audible = (period_i >= PW'(2));

    // Tone counter: 0..period-1, wraps; cleared on restart or when idle
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            cnt_q <= '0;
        else if (restart_i || !enable_i || !audible)
            cnt_q <= '0;
        else if (cnt_q >= period_i - PW'(1))
            cnt_q <= '0;
        else
            cnt_q <= cnt_q + PW'(1);
    end

    // Speaker is high for the upper half of the counter range
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            speaker_o <= 1'b0;
        else
            speaker_o <= enable_i && audible && (cnt_q >= (period_i >> 1));
    end

endmodule

// File: rtl/tone_sequencer.sv
// tone_sequencer: plays a STEPS-deep table of {period, duration} notes on SPEAKER.
// Optional feature macro TONE_SEQ_GAP_EN adds a silent GAP state of GAP_CYCLES clocks
// between every PLAY and the following LOAD (including loop wrap, never before IDLE).
module tone_sequencer
    import tone_pkg::*;
#(
    parameter int STEPS      = 8,
    parameter int PW         = 19,
    parameter int DW         = 26,
    parameter int GAP_CYCLES = 500000
) (
    input  logic                     CLK,
    input  logic                     RST_N,
    input  logic                     WR_EN,
    input  logic [$clog2(STEPS)-1:0] WR_ADDR,
    input  logic [PW-1:0]            WR_PERIOD,
    input  logic [DW-1:0]            WR_DUR,
    input  logic                     START,
    input  logic                     STOP,
    input  logic                     LOOP,
    output logic                     BUSY,
    output logic [$clog2(STEPS)-1:0] STEP,
    output logic [PW-1:0]            PERIOD,
    output logic                     SPEAKER,
    output logic                     DONE
);

    localparam int AW = $clog2(STEPS);
    localparam logic [AW-1:0] LAST_STEP = AW'(STEPS - 1);

    logic [PW-1:0] tbl_per_q [STEPS];
    logic [DW-1:0] tbl_dur_q [STEPS];

    state_e        state_q;
    logic [AW-1:0] step_q;
    logic [PW-1:0] period_q;
    logic [DW-1:0] dcnt_q;
    logic          done_q;
    logic [DW-1:0] ld_dur;
    logic          tone_en;

`ifdef TONE_SEQ_GAP_EN
    localparam int GW = $clog2(GAP_CYCLES + 1);
    logic [GW-1:0] gap_q;
`endif

    // A zero duration still plays for one clock
    assign ld_dur = (tbl_dur_q[step_q] == '0) ? DW'(1) : tbl_dur_q[step_q];

    // Count only while staying in PLAY, so SPEAKER is never high outside PLAY
    assign tone_en = (state_q == ST_PLAY) && !STOP && (dcnt_q > DW'(1));

    // Pattern table: writable in any state; the played note is latched at LOAD
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < STEPS; i++) begin
                tbl_per_q[i] <= '0;
                tbl_dur_q[i] <= '0;
            end
        end else if (WR_EN) begin
            tbl_per_q[WR_ADDR] <= WR_PERIOD;
            tbl_dur_q[WR_ADDR] <= WR_DUR;
        end
    end

    // Sequencing FSM: IDLE -> LOAD -> PLAY [-> GAP] -> LOAD ... -> IDLE; STOP aborts
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= ST_IDLE;
            step_q   <= '0;
            period_q <= '0;
            dcnt_q   <= '0;
            done_q   <= 1'b0;
`ifdef TONE_SEQ_GAP_EN
            gap_q    <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            if (STOP) begin
                state_q  <= ST_IDLE;
                step_q   <= '0;
                period_q <= '0;
                dcnt_q   <= '0;
`ifdef TONE_SEQ_GAP_EN
                gap_q    <= '0;
`endif
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (START) begin
                            state_q <= ST_LOAD;
                            step_q  <= '0;
                        end
                    end
                    ST_LOAD: begin
                        period_q <= tbl_per_q[step_q];
                        dcnt_q   <= ld_dur;
                        state_q  <= ST_PLAY;
                    end
                    ST_PLAY: begin
                        if (dcnt_q > DW'(1)) begin
                            dcnt_q <= dcnt_q - DW'(1);
                        end else begin
                            dcnt_q <= '0;
                            if (step_q == LAST_STEP && !LOOP) begin
                                state_q  <= ST_IDLE;
                                step_q   <= '0;
                                period_q <= '0;
                                done_q   <= 1'b1;
                            end else begin
                                // power-of-two depth: last step wraps to 0 on loop
                                step_q <= step_q + AW'(1);
`ifdef TONE_SEQ_GAP_EN
                                state_q  <= ST_GAP;
                                period_q <= '0;
                                gap_q    <= GW'(GAP_CYCLES - 1);
`else
                                state_q  <= ST_LOAD;
`endif
                            end
                        end
                    end
`ifdef TONE_SEQ_GAP_EN
                    ST_GAP: begin
                        if (gap_q == '0)
                            state_q <= ST_LOAD;
                        else
                            gap_q <= gap_q - GW'(1);
                    end
`endif
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    tone_divider #(.PW(PW)) u_div (
        .clk_i     (CLK),
        .rst_ni    (RST_N),
        .enable_i  (tone_en),
        .restart_i (state_q == ST_LOAD),
        .period_i  (period_q),
        .speaker_o (SPEAKER)
    );

    assign BUSY   = (state_q != ST_IDLE);
    assign STEP   = step_q;
    assign PERIOD = period_q;
    assign DONE   = done_q;

endmodule

// File: tb/tb_tone_sequencer.sv
// tb_tone_sequencer: randomized self-checking bench. Expected output traces are built
// note by note from the table contents (LOAD, PLAY cycles, optional gap, end).
module tb_tone_sequencer;

    localparam int GAPC = 3;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        WR_EN = 1'b0;
    logic [2:0]  WR_ADDR = '0;
    logic [18:0] WR_PERIOD = '0;
    logic [25:0] WR_DUR = '0;
    logic        START = 1'b0;
    logic        STOP = 1'b0;
    logic        LOOP = 1'b0;
    logic        BUSY, SPEAKER, DONE;
    logic [2:0]  STEP;
    logic [18:0] PERIOD;

    typedef struct packed {
        logic        busy;
        logic [2:0]  step;
        logic [18:0] period;
        logic        spk;
        logic        done;
    } exp_t;

    exp_t obs;
    exp_t expq[$];
    int   m_per[8];
    int   m_dur[8];
    int   m_last;
    int   vectors = 0;
    int   errors = 0;

    assign obs = {BUSY, STEP, PERIOD, SPEAKER, DONE};

    tone_sequencer #(.STEPS(8), .PW(19), .DW(26), .GAP_CYCLES(GAPC)) dut (
        .CLK(CLK), .RST_N(RST_N), .WR_EN(WR_EN), .WR_ADDR(WR_ADDR),
        .WR_PERIOD(WR_PERIOD), .WR_DUR(WR_DUR), .START(START), .STOP(STOP),
        .LOOP(LOOP), .BUSY(BUSY), .STEP(STEP), .PERIOD(PERIOD),
        .SPEAKER(SPEAKER), .DONE(DONE)
    );

    always #5 CLK = ~CLK;

    function automatic exp_t mk(bit b, int s, int p, bit sp, bit dn);
        exp_t e;
        e.busy = b; e.step = 3'(s); e.period = 19'(p); e.spk = sp; e.done = dn;
        return e;
    endfunction

    // Append the expected cycles for `count` notes starting at table index `first`
    function automatic void gen_steps(int first, int count, bit lp);
        for (int j = 0; j < count; j++) begin
            int s = (first + j) % 8;
            int p = m_per[s];
            int d = (m_dur[s] == 0) ? 1 : m_dur[s];
            expq.push_back(mk(1'b1, s, m_last, 1'b0, 1'b0));
            for (int k = 0; k < d; k++) begin
                bit sp = 1'b0;
                // square wave: high in the upper half of each period, seen one clock late
                if (k >= 1 && p >= 2) sp = ((k - 1) % p) >= (p / 2);
                expq.push_back(mk(1'b1, s, p, sp, 1'b0));
            end
            m_last = p;
            if (s == 7 && !lp) begin
                expq.push_back(mk(1'b0, 0, 0, 1'b0, 1'b1));
                expq.push_back(mk(1'b0, 0, 0, 1'b0, 1'b0));
                m_last = 0;
            end else begin
`ifdef TONE_SEQ_GAP_EN
                for (int g = 0; g < GAPC; g++) expq.push_back(mk(1'b1, (s + 1) % 8, 0, 1'b0, 1'b0));
                m_last = 0;
`endif
            end
        end
    endfunction

    task automatic wr(input int a, input int p, input int d);
        WR_EN = 1'b1; WR_ADDR = 3'(a); WR_PERIOD = 19'(p); WR_DUR = 26'(d);
        @(negedge CLK);
        WR_EN = 1'b0;
        m_per[a] = p; m_dur[a] = d;
    endtask

    task automatic load_demo_table();
        wr(0, 8, 16); wr(1, 4, 8); wr(2, 0, 4); wr(3, 10, 12);
        wr(4, 1, 3);  wr(5, 6, 0); wr(6, 3, 5); wr(7, 2, 2);
    endtask

    task automatic test_reset();
        RST_N = 1'b0;
        repeat (3) @(negedge CLK);
        vectors++;
        if (obs !== exp_t'(0)) begin
            errors++; $display("FAIL reset_hold: got %h want %h", obs, exp_t'(0));
        end
        RST_N = 1'b1;
        for (int i = 0; i < 8; i++) begin m_per[i] = 0; m_dur[i] = 0; end
        repeat (2) @(negedge CLK);
        vectors++;
        if (obs !== exp_t'(0)) begin
            errors++; $display("FAIL reset_idle: got %h want %h", obs, exp_t'(0));
        end
    endtask

    task automatic test_single_pass();
        load_demo_table();
        expq.delete(); m_last = 0;
        gen_steps(0, 8, 1'b0);
        LOOP = 1'b0; START = 1'b1;
        for (int i = 0; i < expq.size(); i++) begin
            @(negedge CLK); START = 1'b0; vectors++;
            if (obs !== expq[i]) begin
                errors++; $display("FAIL single_pass cyc %0d: got %h want %h", i, obs, expq[i]);
            end
        end
    endtask

    task automatic test_random_pass();
        for (int r = 0; r < 3; r++) begin
            int ign;
            for (int a = 0; a < 8; a++) wr(a, int'($urandom_range(0, 12)), int'($urandom_range(0, 9)));
            expq.delete(); m_last = 0;
            gen_steps(0, 8, 1'b0);
            ign = int'($urandom_range(2, expq.size() - 4));
            LOOP = 1'b0; START = 1'b1;
            for (int i = 0; i < expq.size(); i++) begin
                @(negedge CLK);
                START = (i == ign); // must be ignored while busy
                vectors++;
                if (obs !== expq[i]) begin
                    errors++; $display("FAIL random_pass%0d cyc %0d: got %h want %h", r, i, obs, expq[i]);
                end
            end
            START = 1'b0;
        end
    endtask

    task automatic test_loop();
        for (int a = 0; a < 8; a++) wr(a, int'($urandom_range(0, 12)), 5);
        expq.delete(); m_last = 0;
        gen_steps(0, 20, 1'b1);
        LOOP = 1'b1; START = 1'b1;
        for (int i = 0; i < expq.size(); i++) begin
            @(negedge CLK); START = 1'b0; vectors++;
            if (obs !== expq[i]) begin
                errors++; $display("FAIL loop cyc %0d: got %h want %h", i, obs, expq[i]);
            end
        end
        STOP = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK); STOP = 1'b0; vectors++;
            if (obs !== exp_t'(0)) begin
                errors++; $display("FAIL loop_stop cyc %0d: got %h want %h", i, obs, exp_t'(0));
            end
        end
        LOOP = 1'b0;
    endtask

    task automatic test_stop_start();
        int cut;
        load_demo_table();
        expq.delete(); m_last = 0;
        gen_steps(0, 3, 1'b0);
        cut = expq.size() + 4; // step 3, fourth PLAY cycle
        gen_steps(3, 1, 1'b0);
        LOOP = 1'b0; START = 1'b1;
        for (int i = 0; i <= cut; i++) begin
            @(negedge CLK); START = 1'b0; vectors++;
            if (obs !== expq[i]) begin
                errors++; $display("FAIL stop_run cyc %0d: got %h want %h", i, obs, expq[i]);
            end
        end
        STOP = 1'b1; START = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK); STOP = 1'b0; START = 1'b0; vectors++;
            if (obs !== exp_t'(0)) begin
                errors++; $display("FAIL stop_idle cyc %0d: got %h want %h", i, obs, exp_t'(0));
            end
        end
    endtask

    task automatic test_rewrite();
        int widx;
        for (int a = 0; a < 8; a++) wr(a, int'($urandom_range(2, 12)), int'($urandom_range(2, 6)));
        wr(2, 8, 12);
        expq.delete(); m_last = 0;
        gen_steps(0, 2, 1'b1);
        widx = expq.size() + 1; // first PLAY cycle of step 2
        gen_steps(2, 1, 1'b1);
        m_per[2] = 6;           // visible from the next LOAD of step 2
        gen_steps(3, 8, 1'b1);
        WR_ADDR = 3'd2; WR_PERIOD = 19'd6; WR_DUR = 26'd12;
        LOOP = 1'b1; START = 1'b1;
        for (int i = 0; i < expq.size(); i++) begin
            @(negedge CLK); START = 1'b0;
            WR_EN = (i == widx);
            vectors++;
            if (obs !== expq[i]) begin
                errors++; $display("FAIL rewrite cyc %0d: got %h want %h", i, obs, expq[i]);
            end
        end
        WR_EN = 1'b0; STOP = 1'b1;
        @(negedge CLK); STOP = 1'b0; LOOP = 1'b0; vectors++;
        if (obs !== exp_t'(0)) begin
            errors++; $display("FAIL rewrite_stop: got %h want %h", obs, exp_t'(0));
        end
    endtask

    task automatic test_async_reset();
        load_demo_table();
        expq.delete(); m_last = 0;
        gen_steps(0, 1, 1'b0);
        LOOP = 1'b0; START = 1'b1;
        for (int i = 0; i <= 7; i++) begin // stop where step 0 speaker is high
            @(negedge CLK); START = 1'b0; vectors++;
            if (obs !== expq[i]) begin
                errors++; $display("FAIL areset_run cyc %0d: got %h want %h", i, obs, expq[i]);
            end
        end
        #2 RST_N = 1'b0;
        #1 vectors++;
        if (obs !== exp_t'(0)) begin
            errors++; $display("FAIL areset_async: got %h want %h", obs, exp_t'(0));
        end
        @(negedge CLK); RST_N = 1'b1;
        for (int a = 0; a < 8; a++) begin m_per[a] = 0; m_dur[a] = 0; end
        expq.delete(); m_last = 0;
        gen_steps(0, 8, 1'b0);
        START = 1'b1;
        for (int i = 0; i < expq.size(); i++) begin
            @(negedge CLK); START = 1'b0; vectors++;
            if (obs !== expq[i]) begin
                errors++; $display("FAIL areset_replay cyc %0d: got %h want %h", i, obs, expq[i]);
            end
        end
    endtask

    initial begin
        @(negedge CLK);
        test_reset();
        test_single_pass();
        test_random_pass();
        test_loop();
        test_stop_start();
        test_rewrite();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
